// File: rtl/ibex_rf_write_arbiter.sv
// Register-file W1 arbiter: LSU responses win the port; EX results bypass or queue in order.
// Optional IBEX_RF_WB_FWD_EN: forward in-flight write data instead of stalling decode on it.
module ibex_rf_write_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_req_waddr_i,
  input  logic                 lsu_rvalid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 stall_o
);

  localparam int unsigned CntW     = $clog2(FifoDepth + 1);
  localparam logic [4:0]  AddrMask = RV32E ? 5'h0f : 5'h1f;

  typedef struct packed {
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t          fifo_q     [FifoDepth];
  entry_t          fifo_shift [FifoDepth];
  entry_t          enq_entry;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] wr_pos;
  logic [31:0]     sb_q;

  logic [4:0] ex_idx;
  logic [4:0] req_idx;
  logic [4:0] rsp_idx;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       ex_acc;
  logic       bypass;
  logic       enq;

  logic [4:0] rd_idx  [2];
  logic       rd_pend [2];

  assign ex_idx    = ex_waddr_i & AddrMask;
  assign req_idx   = lsu_req_waddr_i & AddrMask;
  assign rsp_idx   = lsu_waddr_i & AddrMask;
  assign rd_idx[0] = raddr_a_i & AddrMask;
  assign rd_idx[1] = raddr_b_i & AddrMask;
  assign enq_entry = '{addr: ex_idx, data: ex_wdata_i};

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CntW'(FifoDepth));
    pop        = !lsu_rvalid_i && !fifo_empty;
    ex_ready_o = !(fifo_full && !pop) && !sb_q[ex_idx];
    ex_acc     = ex_we_i && ex_ready_o;
    // EX may only bypass when nothing older is queued and the LSU is idle.
    bypass     = ex_acc && fifo_empty && !lsu_rvalid_i;
    enq        = ex_acc && !bypass && (ex_idx != '0);
    wr_pos     = pop ? (count_q - CntW'(1)) : count_q;

    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (lsu_rvalid_i) begin
      if (rsp_idx != '0) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = rsp_idx;
        rf_wdata_o = lsu_wdata_i;
      end
    end else if (pop) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = fifo_q[0].addr;
      rf_wdata_o = fifo_q[0].data;
    end else if (bypass && (ex_idx != '0)) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = ex_idx;
      rf_wdata_o = ex_wdata_i;
    end
  end

  always_comb begin
    fifo_shift = fifo_q;
    for (int unsigned i = 1; i < FifoDepth; i++) begin
      fifo_shift[i-1] = fifo_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      count_q <= count_q + CntW'(enq) - CntW'(pop);
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        if (enq && (CntW'(i) == wr_pos)) begin
          fifo_q[i] <= enq_entry;
        end else if (pop) begin
          fifo_q[i] <= fifo_shift[i];
        end
      end
    end
  end

  // Set is applied after clear so a same-register request wins over a response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q <= '0;
    end else begin
      if (lsu_rvalid_i) begin
        sb_q[rsp_idx] <= 1'b0;
      end
      if (lsu_req_i && (req_idx != '0)) begin
        sb_q[req_idx] <= 1'b1;
      end
    end
  end

`ifdef IBEX_RF_WB_FWD_EN
  logic [DataWidth-1:0] rd_rf   [2];
  logic [DataWidth-1:0] rd_data [2];

  assign rd_rf[0] = rf_rdata_a_i;
  assign rd_rf[1] = rf_rdata_b_i;

  // A response to a pending register is forwarded from the write port, so it no longer stalls.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_pend[p] = sb_q[rd_idx[p]] && !(lsu_rvalid_i && (rsp_idx == rd_idx[p]));
      rd_data[p] = rd_rf[p];
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        if ((CntW'(i) < count_q) && (fifo_q[i].addr == rd_idx[p])) begin
          rd_data[p] = fifo_q[i].data;
        end
      end
      if (rf_we_o && (rf_waddr_o == rd_idx[p])) begin
        rd_data[p] = rf_wdata_o;
      end
      if (rd_idx[p] == '0) begin
        rd_pend[p] = 1'b0;
        rd_data[p] = '0;
      end
    end
  end

  assign rdata_a_o = rd_data[0];
  assign rdata_b_o = rd_data[1];
`else
  // Without forwarding any in-flight write to the operand also counts as not yet available.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_pend[p] = sb_q[rd_idx[p]] || (rf_we_o && (rf_waddr_o == rd_idx[p]));
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        if ((CntW'(i) < count_q) && (fifo_q[i].addr == rd_idx[p])) begin
          rd_pend[p] = 1'b1;
        end
      end
      if (rd_idx[p] == '0) begin
        rd_pend[p] = 1'b0;
      end
    end
  end

  assign rdata_a_o = rf_rdata_a_i;
  assign rdata_b_o = rf_rdata_b_i;
`endif

  assign stall_o = rd_pend[0] || rd_pend[1];

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Directed bench for ibex_rf_write_arbiter with a simple register-file model on the write port.
module tb_ibex_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        ex_ready;
  logic        lsu_req;
  logic [4:0]  lsu_req_waddr;
  logic        lsu_rvalid;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rf_rdata_a;
  logic [31:0] rf_rdata_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];
  logic [31:0] written = '0;

  ibex_rf_write_arbiter #(
    .RV32E    (1'b0),
    .DataWidth(32),
    .FifoDepth(2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ex_we_i        (ex_we),
    .ex_waddr_i     (ex_waddr),
    .ex_wdata_i     (ex_wdata),
    .ex_ready_o     (ex_ready),
    .lsu_req_i      (lsu_req),
    .lsu_req_waddr_i(lsu_req_waddr),
    .lsu_rvalid_i   (lsu_rvalid),
    .lsu_waddr_i    (lsu_waddr),
    .lsu_wdata_i    (lsu_wdata),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .raddr_a_i      (raddr_a),
    .raddr_b_i      (raddr_b),
    .rf_rdata_a_i   (rf_rdata_a),
    .rf_rdata_b_i   (rf_rdata_b),
    .rdata_a_o      (rdata_a),
    .rdata_b_o      (rdata_b),
    .stall_o        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: x0 reads 0, untouched xN reads 0x1000+N, writes land at the clock edge.
  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (written[a]) return regs[a];
    return {27'h80, a};
  endfunction

  always @(posedge clk) begin
    if (rf_we) begin
      regs[rf_waddr]    <= rf_wdata;
      written[rf_waddr] <= 1'b1;
    end
  end

  assign rf_rdata_a = rf_read(raddr_a);
  assign rf_rdata_b = rf_read(raddr_b);

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
    lsu_req = 1'b0; lsu_req_waddr = '0; lsu_rvalid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    raddr_a = 5'd3; raddr_b = 5'd0;
    #1 rst = 1'b1;
    #2;
    chk1 ("rst_we", rf_we, 1'b0);
    chk32("rst_waddr", 32'(rf_waddr), 32'd0);
    chk32("rst_wdata", rf_wdata, 32'h0);
    chk1 ("rst_stall", stall, 1'b0);
    chk1 ("rst_ready", ex_ready, 1'b1);
    chk32("rst_rdata_a", rdata_a, 32'h1003);
    next_cycle();
    rst = 1'b0; raddr_a = 5'd0;
    next_cycle();

    // EX bypass to x5
    ex_we = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h1234; raddr_a = 5'd5;
    #2;
    chk1 ("t1_we", rf_we, 1'b1);
    chk32("t1_waddr", 32'(rf_waddr), 32'd5);
    chk32("t1_wdata", rf_wdata, 32'h1234);
    chk1 ("t1_ready", ex_ready, 1'b1);
`ifdef IBEX_RF_WB_FWD_EN
    chk32("t1_fwd_rdata", rdata_a, 32'h1234);
    chk1 ("t1_fwd_stall", stall, 1'b0);
`else
    chk1 ("t1_stall", stall, 1'b1);
    chk32("t1_rdata_old", rdata_a, 32'h1005);
`endif
    next_cycle();
    ex_we = 1'b0;
    #2;
    chk1 ("t1_idle_we", rf_we, 1'b0);
    chk32("t1_next_rdata", rdata_a, 32'h1234);
    chk1 ("t1_next_stall", stall, 1'b0);
    next_cycle();

    // Load wins, EX x8 queued behind it
    lsu_rvalid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'hAA;
    ex_we = 1'b1; ex_waddr = 5'd8; ex_wdata = 32'hBB; raddr_a = 5'd8;
    #2;
    chk1 ("t2_we", rf_we, 1'b1);
    chk32("t2_waddr", 32'(rf_waddr), 32'd7);
    chk32("t2_wdata", rf_wdata, 32'hAA);
    chk1 ("t2_ready", ex_ready, 1'b1);
    chk1 ("t2_stall", stall, 1'b0);
    chk32("t2_rdata", rdata_a, 32'h1008);
    next_cycle();
    lsu_rvalid = 1'b0; ex_we = 1'b0;
    #2;
    chk1 ("t2_q_we", rf_we, 1'b1);
    chk32("t2_q_waddr", 32'(rf_waddr), 32'd8);
    chk32("t2_q_wdata", rf_wdata, 32'hBB);
    chk1 ("t2_q_ready", ex_ready, 1'b1);
`ifdef IBEX_RF_WB_FWD_EN
    chk32("t2_fwd_rdata", rdata_a, 32'hBB);
    chk1 ("t2_fwd_stall", stall, 1'b0);
`else
    chk1 ("t2_q_stall", stall, 1'b1);
`endif
    next_cycle();
    #2;
    chk1 ("t2_idle_we", rf_we, 1'b0);
    chk32("t2_rf_rdata", rdata_a, 32'hBB);
    chk1 ("t2_idle_stall", stall, 1'b0);
    next_cycle();

    // Three back-to-back loads with EX every cycle fill the depth-2 FIFO
    raddr_a = 5'd0;
    lsu_rvalid = 1'b1; lsu_waddr = 5'd10; lsu_wdata = 32'hA10;
    ex_we = 1'b1; ex_waddr = 5'd11; ex_wdata = 32'hE11;
    #2;
    chk32("t3_c1_waddr", 32'(rf_waddr), 32'd10);
    chk1 ("t3_c1_ready", ex_ready, 1'b1);
    next_cycle();
    lsu_waddr = 5'd12; lsu_wdata = 32'hA12; ex_waddr = 5'd13; ex_wdata = 32'hE13;
    #2;
    chk32("t3_c2_waddr", 32'(rf_waddr), 32'd12);
    chk1 ("t3_c2_ready", ex_ready, 1'b1);
    next_cycle();
    lsu_waddr = 5'd14; lsu_wdata = 32'hA14; ex_waddr = 5'd15; ex_wdata = 32'hE15;
    #2;
    chk32("t3_c3_waddr", 32'(rf_waddr), 32'd14);
    chk32("t3_c3_wdata", rf_wdata, 32'hA14);
    chk1 ("t3_c3_ready", ex_ready, 1'b0);
    next_cycle();
    lsu_rvalid = 1'b0; raddr_b = 5'd13;
    #2;
    chk32("t3_c4_waddr", 32'(rf_waddr), 32'd11);
    chk32("t3_c4_wdata", rf_wdata, 32'hE11);
    chk1 ("t3_c4_ready", ex_ready, 1'b1);
`ifdef IBEX_RF_WB_FWD_EN
    chk32("t3_fwd_rdata_b", rdata_b, 32'hE13);
    chk1 ("t3_fwd_stall", stall, 1'b0);
`else
    chk1 ("t3_c4_stall", stall, 1'b1);
`endif
    next_cycle();
    ex_we = 1'b0; raddr_b = 5'd0;
    #2;
    chk32("t3_c5_waddr", 32'(rf_waddr), 32'd13);
    chk32("t3_c5_wdata", rf_wdata, 32'hE13);
    next_cycle();
    #2;
    chk32("t3_c6_waddr", 32'(rf_waddr), 32'd15);
    chk32("t3_c6_wdata", rf_wdata, 32'hE15);
    next_cycle();
    #2;
    chk1 ("t3_c7_we", rf_we, 1'b0);
    next_cycle();

    // Pending load on x9: stall and WAW hold-off
    lsu_req = 1'b1; lsu_req_waddr = 5'd9;
    #2;
    chk1 ("t4_req_stall", stall, 1'b0);
    next_cycle();
    lsu_req = 1'b0; raddr_a = 5'd9;
    ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h9E;
    #2;
    chk1 ("t4_p1_stall", stall, 1'b1);
    chk1 ("t4_p1_ready", ex_ready, 1'b0);
    chk1 ("t4_p1_we", rf_we, 1'b0);
    next_cycle();
    #2;
    chk1 ("t4_p2_stall", stall, 1'b1);
    chk1 ("t4_p2_ready", ex_ready, 1'b0);
    next_cycle();
    lsu_rvalid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h99;
    #2;
    chk1 ("t4_rsp_we", rf_we, 1'b1);
    chk32("t4_rsp_waddr", 32'(rf_waddr), 32'd9);
    chk32("t4_rsp_wdata", rf_wdata, 32'h99);
    chk1 ("t4_rsp_ready", ex_ready, 1'b0);
`ifdef IBEX_RF_WB_FWD_EN
    chk1 ("t4_fwd_stall", stall, 1'b0);
    chk32("t4_fwd_rdata", rdata_a, 32'h99);
`else
    chk1 ("t4_rsp_stall", stall, 1'b1);
`endif
    next_cycle();
    lsu_rvalid = 1'b0;
    #2;
    chk1 ("t4_ex_ready", ex_ready, 1'b1);
    chk1 ("t4_ex_we", rf_we, 1'b1);
    chk32("t4_ex_waddr", 32'(rf_waddr), 32'd9);
    chk32("t4_ex_wdata", rf_wdata, 32'h9E);
`ifdef IBEX_RF_WB_FWD_EN
    chk1 ("t4_ex_fwd_stall", stall, 1'b0);
    chk32("t4_ex_fwd_rdata", rdata_a, 32'h9E);
`else
    chk1 ("t4_ex_stall", stall, 1'b1);
    chk32("t4_ex_rdata", rdata_a, 32'h99);
`endif
    next_cycle();
    ex_we = 1'b0;
    #2;
    chk1 ("t4_end_stall", stall, 1'b0);
    chk32("t4_end_rdata", rdata_a, 32'h9E);
    next_cycle();

    // x0 from both sources
    ex_we = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hFFFF;
    lsu_req = 1'b1; lsu_req_waddr = 5'd0; raddr_a = 5'd0; raddr_b = 5'd0;
    #2;
    chk1 ("t5_we", rf_we, 1'b0);
    chk32("t5_waddr", 32'(rf_waddr), 32'd0);
    chk32("t5_wdata", rf_wdata, 32'h0);
    chk1 ("t5_ready", ex_ready, 1'b1);
    chk32("t5_rdata", rdata_a, 32'h0);
    next_cycle();
    ex_we = 1'b0; lsu_req = 1'b0;
    lsu_rvalid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'h5555;
    #2;
    chk1 ("t5_ld_we", rf_we, 1'b0);
    chk32("t5_ld_wdata", rf_wdata, 32'h0);
    chk1 ("t5_stall", stall, 1'b0);
    chk1 ("t5_ld_ready", ex_ready, 1'b1);
    next_cycle();
    lsu_rvalid = 1'b0;
    #2;
    chk1 ("t5_empty_we", rf_we, 1'b0);
    next_cycle();

    // Reset with two queued EX results and x3 pending
    lsu_req = 1'b1; lsu_req_waddr = 5'd3;
    lsu_rvalid = 1'b1; lsu_waddr = 5'd20; lsu_wdata = 32'hA20;
    ex_we = 1'b1; ex_waddr = 5'd21; ex_wdata = 32'hE21;
    #2;
    chk1 ("t6_c1_ready", ex_ready, 1'b1);
    next_cycle();
    lsu_req = 1'b0; lsu_waddr = 5'd22; lsu_wdata = 32'hA22;
    ex_waddr = 5'd23; ex_wdata = 32'hE23;
    #2;
    chk1 ("t6_c2_ready", ex_ready, 1'b1);
    next_cycle();
    lsu_rvalid = 1'b0; ex_we = 1'b0; raddr_a = 5'd3;
    #2;
    chk1 ("t6_pre_stall", stall, 1'b1);
    chk32("t6_pre_waddr", 32'(rf_waddr), 32'd21);
    #1 rst = 1'b1;
    #1;
    chk1 ("t6_rst_we", rf_we, 1'b0);
    chk32("t6_rst_waddr", 32'(rf_waddr), 32'd0);
    chk1 ("t6_rst_stall", stall, 1'b0);
    chk1 ("t6_rst_ready", ex_ready, 1'b1);
    next_cycle();
    rst = 1'b0;
    #2;
    chk1 ("t6_post_we", rf_we, 1'b0);
    chk1 ("t6_post_stall", stall, 1'b0);
    next_cycle();
    ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h3333;
    #2;
    chk1 ("t6_ex_ready", ex_ready, 1'b1);
    chk32("t6_ex_waddr", 32'(rf_waddr), 32'd3);
    chk32("t6_ex_wdata", rf_wdata, 32'h3333);
    next_cycle();
    ex_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
